rename_commit_queue: RTL and testbench



---
 rtl/rename_commit_queue_pkg.sv | 36 +++
 rtl/rename_commit_queue_if.sv | 43 ++++
 rtl/rename_commit_queue_entry_array.sv | 66 ++++++
 rtl/rename_commit_queue.sv | 86 ++++++++
 tb/tb_rename_commit_queue.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_commit_queue_pkg.sv
// Shared types for the rename commit queue: default widths, per-entry status
// flags and the {DO_REL, DO_ROLL} rollback command encoding.
package rename_commit_queue_pkg;

    localparam int NAME_WIDTH    = 1;
    localparam int REPLICA_WIDTH = 1;
    localparam int DEPTH         = 8;
    localparam int PTR_WIDTH     = 3;

    typedef struct packed {
        logic valid;
        logic done;
        logic misp;
        logic has_chk;
    } commit_flags_t;

    // Bit 1 drives DO_REL, bit 0 drives DO_ROLL.
    typedef enum logic [1:0] {
        CMD_NONE                = 2'b00,
        CMD_RESTORE_KEEP        = 2'b01,
        CMD_RELEASE_ONE         = 2'b10,
        CMD_RESTORE_RELEASE_ALL = 2'b11
    } rollbk_cmd_e;

    // Only checkpointed entries talk to the rollback port, and misp is only
    // ever set on checkpointed entries, so a misprediction always restores.
    function automatic rollbk_cmd_e rollbk_cmd(input commit_flags_t head);
        rollbk_cmd_e cmd;
        cmd = CMD_NONE;
        if (head.valid && head.done && head.has_chk) begin
            cmd = head.misp ? CMD_RESTORE_RELEASE_ALL : CMD_RELEASE_ONE;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/rename_commit_queue_if.sv
// Enqueue, completion, free and rollback signals of the commit queue.
// The master side is the queue itself; the slave side is the pipeline.
interface rename_commit_queue_if #(
    parameter int name_width    = 1,
    parameter int replica_width = 1,
    parameter int ptr_width     = 3
) ();

    logic                     ENQ_E;
    logic [name_width-1:0]    ENQ_NAME;
    logic                     ENQ_HAS_CHK;
    logic [replica_width-1:0] ENQ_CHK;
    logic                     ENQ_READY;
    logic [ptr_width-1:0]     ENQ_IDX;

    logic                     DONE_E;
    logic [ptr_width-1:0]     DONE_IDX;
    logic                     DONE_MISP;

    logic [name_width-1:0]    NAME_F;
    logic                     FE;
    logic [replica_width-1:0] ROLLBK_IN;
    logic                     ROLLBK_E;
    logic                     DO_ROLL;
    logic                     DO_REL;
    logic                     FLUSH;
    logic                     EMPTY;

    modport master (
        input  ENQ_E, ENQ_NAME, ENQ_HAS_CHK, ENQ_CHK,
        input  DONE_E, DONE_IDX, DONE_MISP,
        output ENQ_READY, ENQ_IDX,
        output NAME_F, FE, ROLLBK_IN, ROLLBK_E, DO_ROLL, DO_REL, FLUSH, EMPTY
    );

    modport slave (
        output ENQ_E, ENQ_NAME, ENQ_HAS_CHK, ENQ_CHK,
        output DONE_E, DONE_IDX, DONE_MISP,
        input  ENQ_READY, ENQ_IDX,
        input  NAME_F, FE, ROLLBK_IN, ROLLBK_E, DO_ROLL, DO_REL, FLUSH, EMPTY
    );

endinterface

// File: rtl/rename_commit_queue_entry_array.sv
// Commit queue entry storage: tail write port, completion update port,
// head read/retire port and a bulk clear used by reset and flush.
module rename_commit_queue_entry_array
    import rename_commit_queue_pkg::*;
#(
    parameter int name_width    = NAME_WIDTH,
    parameter int replica_width = REPLICA_WIDTH,
    parameter int depth         = DEPTH,
    parameter int ptr_width     = PTR_WIDTH
) (
    input  logic                     CLK,
    input  logic                     i_clear,
    input  logic                     i_wr_e,
    input  logic [ptr_width-1:0]     i_wr_idx,
    input  logic [name_width-1:0]    i_wr_name,
    input  logic                     i_wr_has_chk,
    input  logic [replica_width-1:0] i_wr_chk,
    input  logic                     i_done_e,
    input  logic [ptr_width-1:0]     i_done_idx,
    input  logic                     i_done_misp,
    input  logic                     i_retire,
    input  logic [ptr_width-1:0]     i_head_idx,
    output commit_flags_t            o_head_flags,
    output logic [name_width-1:0]    o_head_name,
    output logic [replica_width-1:0] o_head_chk
);

    commit_flags_t            r_flags [depth];
    logic [name_width-1:0]    r_name  [depth];
    logic [replica_width-1:0] r_chk   [depth];

    // Later assignments take priority: a fresh enqueue overrides anything
    // else touching the same slot, and a completion aimed at an invalid slot
    // is dropped so a stale DONE cannot pre-complete a future entry.
    always_ff @(posedge CLK) begin
        if (i_clear) begin
            for (int i = 0; i < depth; i++) begin
                r_flags[i] <= '0;
            end
        end else begin
            if (i_retire) begin
                r_flags[i_head_idx] <= '0;
            end
            if (i_done_e && r_flags[i_done_idx].valid) begin
                r_flags[i_done_idx].done <= 1'b1;
                r_flags[i_done_idx].misp <= i_done_misp && r_flags[i_done_idx].has_chk;
            end
            if (i_wr_e) begin
                r_flags[i_wr_idx] <= '{valid: 1'b1, done: 1'b0, misp: 1'b0,
                                       has_chk: i_wr_has_chk};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (i_wr_e) begin
            r_name[i_wr_idx] <= i_wr_name;
            r_chk[i_wr_idx]  <= i_wr_chk;
        end
    end

    assign o_head_flags = r_flags[i_head_idx];
    assign o_head_name  = r_name[i_head_idx];
    assign o_head_chk   = r_chk[i_head_idx];

endmodule

// File: rtl/rename_commit_queue.sv
// In-order commit queue behind the checkpointing rename file: frees names at
// retirement and issues checkpoint release/restore, flushing on mispredicts.
module rename_commit_queue
    import rename_commit_queue_pkg::*;
#(
    parameter int name_width    = NAME_WIDTH,
    parameter int replica_width = REPLICA_WIDTH,
    parameter int depth         = DEPTH,
    parameter int ptr_width     = PTR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    rename_commit_queue_if.master bus
);

    logic [ptr_width-1:0]     r_head;
    logic [ptr_width-1:0]     r_tail;
    logic [ptr_width:0]       r_count;

    commit_flags_t            w_head_flags;
    logic [name_width-1:0]    w_head_name;
    logic [replica_width-1:0] w_head_chk;
    logic                     w_commit;
    logic                     w_flush;
    logic                     w_enq_ready;
    logic                     w_enq_fire;
    logic                     w_clear;
    rollbk_cmd_e              w_cmd;

    rename_commit_queue_entry_array #(
        .name_width    (name_width),
        .replica_width (replica_width),
        .depth         (depth),
        .ptr_width     (ptr_width)
    ) u_entries (
        .CLK          (CLK),
        .i_clear      (w_clear),
        .i_wr_e       (w_enq_fire),
        .i_wr_idx     (r_tail),
        .i_wr_name    (bus.ENQ_NAME),
        .i_wr_has_chk (bus.ENQ_HAS_CHK),
        .i_wr_chk     (bus.ENQ_CHK),
        .i_done_e     (bus.DONE_E),
        .i_done_idx   (bus.DONE_IDX),
        .i_done_misp  (bus.DONE_MISP),
        .i_retire     (w_commit),
        .i_head_idx   (r_head),
        .o_head_flags (w_head_flags),
        .o_head_name  (w_head_name),
        .o_head_chk   (w_head_chk)
    );

    assign w_commit = w_head_flags.valid && w_head_flags.done;
    assign w_flush  = w_commit && w_head_flags.misp;
    assign w_clear  = RST || w_flush;
    assign w_cmd    = rollbk_cmd(w_head_flags);

    // Ready depends only on registered occupancy, so a same-cycle retirement
    // never opens a slot, and a flush keeps rename from allocating during restore.
    assign w_enq_ready = (r_count != (ptr_width + 1)'(depth)) && !w_flush;
    assign w_enq_fire  = bus.ENQ_E && w_enq_ready;

    assign bus.ENQ_READY = w_enq_ready;
    assign bus.ENQ_IDX   = r_tail;
    assign bus.EMPTY     = (r_count == '0);
    assign bus.FE        = w_commit;
    assign bus.NAME_F    = w_commit ? w_head_name : '0;
    assign bus.DO_REL    = w_cmd[1];
    assign bus.DO_ROLL   = w_cmd[0];
    assign bus.ROLLBK_E  = (w_cmd != CMD_NONE);
    assign bus.ROLLBK_IN = (w_cmd != CMD_NONE) ? w_head_chk : '0;
    assign bus.FLUSH     = w_flush;

    always_ff @(posedge CLK) begin
        if (RST || w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + ptr_width'(w_commit);
            r_tail  <= r_tail + ptr_width'(w_enq_fire);
            r_count <= r_count + (ptr_width + 1)'(w_enq_fire) - (ptr_width + 1)'(w_commit);
        end
    end

endmodule

// File: tb/tb_rename_commit_queue.sv
// Directed bench for rename_commit_queue: a program-order queue model checked
// every cycle, plus hand-computed expectations at the key cycles.
module tb_rename_commit_queue;

    localparam int NW = 4;
    localparam int RW = 2;
    localparam int QD = 8;
    localparam int PW = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    rename_commit_queue_if #(.name_width(NW), .replica_width(RW), .ptr_width(PW)) bus ();

    rename_commit_queue #(
        .name_width    (NW),
        .replica_width (RW),
        .depth         (QD),
        .ptr_width     (PW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        int idx;
        int name;
        bit hasChk;
        int chk;
        bit done;
        bit misp;
    } mEntry_t;

    mEntry_t mq[$];
    int      mTail    = 0;
    int      nChecks  = 0;
    int      nFail    = 0;
    bit      checking = 1'b0;

    task automatic checkOutput(input string what, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", what, $time, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input bit enq, input int name, input bit hasChk, input int chk,
                                 input bit done, input int idx, input bit misp);
        bus.ENQ_E       = enq;
        bus.ENQ_NAME    = NW'(name);
        bus.ENQ_HAS_CHK = hasChk;
        bus.ENQ_CHK     = RW'(chk);
        bus.DONE_E      = done;
        bus.DONE_IDX    = PW'(idx);
        bus.DONE_MISP   = misp;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // Model update: entries live in program order; the head retires once done.
    always @(posedge CLK) begin
        bit mCommit, mFlush, mReady;
        if (RST) begin
            mq.delete();
            mTail = 0;
        end else begin
            mCommit = (mq.size() > 0) && mq[0].done;
            mFlush  = mCommit && mq[0].misp;
            mReady  = (mq.size() < QD) && !mFlush;
            if (bus.DONE_E) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].idx == int'(bus.DONE_IDX)) begin
                        mq[i].done = 1'b1;
                        mq[i].misp = bus.DONE_MISP && mq[i].hasChk;
                    end
                end
            end
            if (mFlush) begin
                mq.delete();
                mTail = 0;
            end else begin
                if (mCommit) void'(mq.pop_front());
                if (bus.ENQ_E && mReady) begin
                    mEntry_t e;
                    e.idx    = mTail;
                    e.name   = int'(bus.ENQ_NAME);
                    e.hasChk = bus.ENQ_HAS_CHK;
                    e.chk    = int'(bus.ENQ_CHK);
                    e.done   = 1'b0;
                    e.misp   = 1'b0;
                    mq.push_back(e);
                    mTail = (mTail + 1) % QD;
                end
            end
        end
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge CLK) begin
        bit eCommit, eFlush, eRoll;
        int eName, eChk;
        if (checking && !RST) begin
            eCommit = (mq.size() > 0) && mq[0].done;
            eFlush  = eCommit && mq[0].misp;
            eRoll   = eCommit && mq[0].hasChk;
            eName   = eCommit ? mq[0].name : 0;
            eChk    = eRoll ? mq[0].chk : 0;
            checkOutput("model_FE",        32'(bus.FE),        32'(eCommit));
            checkOutput("model_NAME_F",    32'(bus.NAME_F),    32'(eName));
            checkOutput("model_ROLLBK_E",  32'(bus.ROLLBK_E),  32'(eRoll));
            checkOutput("model_ROLLBK_IN", 32'(bus.ROLLBK_IN), 32'(eChk));
            checkOutput("model_DO_REL",    32'(bus.DO_REL),    32'(eRoll));
            checkOutput("model_DO_ROLL",   32'(bus.DO_ROLL),   32'(eFlush));
            checkOutput("model_FLUSH",     32'(bus.FLUSH),     32'(eFlush));
            checkOutput("model_ENQ_READY", 32'(bus.ENQ_READY), 32'((mq.size() < QD) && !eFlush));
            checkOutput("model_ENQ_IDX",   32'(bus.ENQ_IDX),   32'(mTail));
            checkOutput("model_EMPTY",     32'(bus.EMPTY),     32'(mq.size() == 0));
        end
    end

    initial begin
        idle();
        tick();
        tick();
        RST = 1'b0;
        checking = 1'b1;
        #2;
        checkOutput("rst_ENQ_READY", 32'(bus.ENQ_READY), 32'd1);
        checkOutput("rst_ENQ_IDX",   32'(bus.ENQ_IDX),   32'd0);
        checkOutput("rst_EMPTY",     32'(bus.EMPTY),     32'd1);
        checkOutput("rst_FE",        32'(bus.FE),        32'd0);
        checkOutput("rst_ROLLBK_E",  32'(bus.ROLLBK_E),  32'd0);
        checkOutput("rst_NAME_F",    32'(bus.NAME_F),    32'd0);

        $display("[TB] in-order commit with out-of-order completion");
        applyStimulus(1'b1, 2, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b1, 3, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b1, 4, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b0);
        #2; checkOutput("oo_no_commit_yet", 32'(bus.FE), 32'd0);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0); tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 2, 1'b0);
        #2; checkOutput("oo_FE0", 32'(bus.FE), 32'd1);
        checkOutput("oo_NAME_F0", 32'(bus.NAME_F), 32'd2);
        tick();
        idle();
        #2; checkOutput("oo_NAME_F1", 32'(bus.NAME_F), 32'd3);
        tick();
        #2; checkOutput("oo_NAME_F2", 32'(bus.NAME_F), 32'd4);
        checkOutput("oo_ROLLBK_E", 32'(bus.ROLLBK_E), 32'd0);
        tick();
        #2; checkOutput("oo_EMPTY", 32'(bus.EMPTY), 32'd1);
        checkOutput("oo_ENQ_IDX", 32'(bus.ENQ_IDX), 32'd3);

        $display("[TB] checkpoint release on correct prediction");
        applyStimulus(1'b1, 5, 1'b1, 1, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b0); tick();
        idle();
        #2; checkOutput("rel_NAME_F",    32'(bus.NAME_F),    32'd5);
        checkOutput("rel_ROLLBK_E",  32'(bus.ROLLBK_E),  32'd1);
        checkOutput("rel_DO_REL",    32'(bus.DO_REL),    32'd1);
        checkOutput("rel_DO_ROLL",   32'(bus.DO_ROLL),   32'd0);
        checkOutput("rel_ROLLBK_IN", 32'(bus.ROLLBK_IN), 32'd1);
        checkOutput("rel_FLUSH",     32'(bus.FLUSH),     32'd0);
        tick();

        $display("[TB] mispredict restore and flush");
        applyStimulus(1'b1, 6, 1'b1, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b1, 7, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b1, 8, 1'b0, 0, 1'b0, 0, 1'b0); tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 4, 1'b1); tick();
        applyStimulus(1'b1, 9, 1'b0, 0, 1'b0, 0, 1'b0);
        #2; checkOutput("misp_FE",        32'(bus.FE),        32'd1);
        checkOutput("misp_NAME_F",    32'(bus.NAME_F),    32'd6);
        checkOutput("misp_DO_ROLL",   32'(bus.DO_ROLL),   32'd1);
        checkOutput("misp_DO_REL",    32'(bus.DO_REL),    32'd1);
        checkOutput("misp_ROLLBK_IN", 32'(bus.ROLLBK_IN), 32'd0);
        checkOutput("misp_FLUSH",     32'(bus.FLUSH),     32'd1);
        checkOutput("misp_ENQ_READY", 32'(bus.ENQ_READY), 32'd0);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 5, 1'b0);
        #2; checkOutput("misp_EMPTY",   32'(bus.EMPTY),   32'd1);
        checkOutput("misp_ENQ_IDX", 32'(bus.ENQ_IDX), 32'd0);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 6, 1'b0); tick();
        idle();
        #2; checkOutput("misp_no_free", 32'(bus.FE), 32'd0);
        tick();

        $display("[TB] full queue and wrap-around");
        for (int i = 0; i < QD; i++) begin
            applyStimulus(1'b1, i + 8, 1'b0, 0, 1'b0, 0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1, 1'b0, 0, 1'b0, 0, 1'b0);
        #2; checkOutput("full_ENQ_READY", 32'(bus.ENQ_READY), 32'd0);
        tick();
        applyStimulus(1'b1, 1, 1'b0, 0, 1'b1, 0, 1'b0);
        #2; checkOutput("full_ignored_IDX", 32'(bus.ENQ_IDX), 32'd0);
        tick();
        applyStimulus(1'b1, 1, 1'b0, 0, 1'b0, 0, 1'b0);
        #2; checkOutput("full_commit_FE",   32'(bus.FE),        32'd1);
        checkOutput("full_commit_name", 32'(bus.NAME_F),    32'd8);
        checkOutput("full_commit_rdy",  32'(bus.ENQ_READY), 32'd0);
        tick();
        #2; checkOutput("wrap_ENQ_READY", 32'(bus.ENQ_READY), 32'd1);
        checkOutput("wrap_ENQ_IDX",   32'(bus.ENQ_IDX),   32'd0);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b0);
        #2; checkOutput("wrap_full_again", 32'(bus.ENQ_READY), 32'd0);
        checkOutput("wrap_tail",       32'(bus.ENQ_IDX),   32'd1);
        tick();
        for (int i = 2; i <= QD; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, i % QD, 1'b0);
            tick();
        end
        idle();
        tick();
        tick();
        #2; checkOutput("drain_EMPTY", 32'(bus.EMPTY), 32'd1);

        $display("[TB] stray completion and mispredict without checkpoint");
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b0); tick();
        applyStimulus(1'b1, 9, 1'b0, 0, 1'b0, 0, 1'b0);
        #2; checkOutput("stray_FE",    32'(bus.FE),    32'd0);
        checkOutput("stray_EMPTY", 32'(bus.EMPTY), 32'd1);
        checkOutput("stray_IDX",   32'(bus.ENQ_IDX), 32'd1);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b1); tick();
        idle();
        #2; checkOutput("nochk_NAME_F",   32'(bus.NAME_F),   32'd9);
        checkOutput("nochk_ROLLBK_E", 32'(bus.ROLLBK_E), 32'd0);
        checkOutput("nochk_FLUSH",    32'(bus.FLUSH),    32'd0);
        tick();

        $display("[TB] reset with completed entries pending");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 10 + i, 1'b0, 0, 1'b0, 0, 1'b0);
            tick();
        end
        for (int i = 3; i <= 5; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, i, 1'b0);
            tick();
        end
        idle();
        #2; checkOutput("blocked_FE",    32'(bus.FE),    32'd0);
        checkOutput("blocked_EMPTY", 32'(bus.EMPTY), 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #2; checkOutput("mrst_EMPTY",    32'(bus.EMPTY),    32'd1);
        checkOutput("mrst_FE",       32'(bus.FE),       32'd0);
        checkOutput("mrst_ROLLBK_E", 32'(bus.ROLLBK_E), 32'd0);
        checkOutput("mrst_ENQ_IDX",  32'(bus.ENQ_IDX),  32'd0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
